// File: rtl/mel_log2_pkg.sv
// Shared constants for the mel log2 block: widths, bin count and the
// log2 fraction table used by the final pipeline stage.
package mel_log2_pkg;

  localparam int unsigned MEL_BINS = 64;
  localparam int unsigned I_BW_DEF = 14;
  localparam int unsigned O_BW_DEF = 10;
  localparam int unsigned IDX_BW   = 6;
  localparam int unsigned GRP_BW   = 7;
  // Integer part (leading-one position) and mantissa widths of the result
  localparam int unsigned P_BW     = 4;
  localparam int unsigned M_BW     = 6;

  // LOG2_FRAC_LUT[m] = round(64 * log2(1 + m/64)), saturated at 63
  localparam logic [M_BW-1:0] LOG2_FRAC_LUT [MEL_BINS] = '{
    6'd0,  6'd1,  6'd3,  6'd4,  6'd6,  6'd7,  6'd8,  6'd10,
    6'd11, 6'd12, 6'd13, 6'd15, 6'd16, 6'd17, 6'd18, 6'd19,
    6'd21, 6'd22, 6'd23, 6'd24, 6'd25, 6'd26, 6'd27, 6'd28,
    6'd29, 6'd30, 6'd31, 6'd32, 6'd34, 6'd35, 6'd35, 6'd36,
    6'd37, 6'd38, 6'd39, 6'd40, 6'd41, 6'd42, 6'd43, 6'd44,
    6'd45, 6'd46, 6'd47, 6'd47, 6'd48, 6'd49, 6'd50, 6'd51,
    6'd52, 6'd52, 6'd53, 6'd54, 6'd55, 6'd56, 6'd56, 6'd57,
    6'd58, 6'd59, 6'd60, 6'd60, 6'd61, 6'd62, 6'd63, 6'd63
  };

endpackage

// File: rtl/mel_lod_norm.sv
// Leading-one detector and normaliser: returns the leading-one position p
// and the 6 bits below it, left-aligned (zero-padded or truncated).
module mel_lod_norm
  import mel_log2_pkg::*;
#(
  parameter int unsigned W = I_BW_DEF - 1
) (
  input  logic [W-1:0]    i_val,
  output logic [P_BW-1:0] o_p,
  output logic [M_BW-1:0] o_m
);

  logic [P_BW-1:0] w_sh;
  logic [W-1:0]    w_norm;
  logic            w_unused_bits;

  // Priority search: highest set bit wins; zero input yields p = 0
  always_comb begin
    o_p = '0;
    for (int i = 0; i < int'(W); i++) begin
      if (i_val[i]) o_p = P_BW'(i);
    end
  end

  // Shift the leading one up to the MSB so the mantissa sits just below it
  assign w_sh   = P_BW'(W - 1) - o_p;
  assign w_norm = i_val << w_sh;
  assign o_m    = w_norm[W-2 -: M_BW];

  assign w_unused_bits = ^{w_norm[W-1], w_norm[W-M_BW-2:0]};

endmodule

// File: rtl/mel_log2.sv
// Three-stage log2 of mel energies (Q4.6 out) with index alignment and an
// input ordering checker.
module mel_log2
  import mel_log2_pkg::*;
#(
  parameter int unsigned I_BW = I_BW_DEF,
  parameter int unsigned O_BW = O_BW_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   di_en,
  input  logic signed [I_BW-1:0] data_i,
  input  logic [IDX_BW-1:0]      in_group_idx,
  input  logic [GRP_BW-1:0]      in_group_num,
  output logic                   do_en,
  output logic [O_BW-1:0]        data_o,
  output logic [IDX_BW-1:0]      out_group_idx,
  output logic [GRP_BW-1:0]      out_group_num,
  output logic                   frame_done,
  output logic                   seq_err
);

  logic              r1_val;
  logic [I_BW-2:0]   r1_data;
  logic [IDX_BW-1:0] r1_idx;
  logic [GRP_BW-1:0] r1_grp;

  logic              r2_val;
  logic [P_BW-1:0]   r2_p;
  logic [M_BW-1:0]   r2_m;
  logic [IDX_BW-1:0] r2_idx;
  logic [GRP_BW-1:0] r2_grp;

  logic [IDX_BW-1:0] r_exp_idx;
  logic [GRP_BW-1:0] r_last_grp;

  logic [I_BW-2:0]   w_clamp;
  logic [P_BW-1:0]   w_p;
  logic [M_BW-1:0]   w_m;
  logic              w_seq_bad;

  // Negative samples clamp to zero; zero already maps to a zero magnitude
  assign w_clamp = data_i[I_BW-1] ? '0 : data_i[I_BW-2:0];

  mel_lod_norm #(
    .W (I_BW - 1)
  ) u_lod_norm (
    .i_val (r1_data),
    .o_p   (w_p),
    .o_m   (w_m)
  );

  // Stage 1: capture clamped sample and its tags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_val  <= 1'b0;
      r1_data <= '0;
      r1_idx  <= '0;
      r1_grp  <= '0;
    end else begin
      r1_val <= di_en;
      if (di_en) begin
        r1_data <= w_clamp;
        r1_idx  <= in_group_idx;
        r1_grp  <= in_group_num;
      end
    end
  end

  // Stage 2: register leading-one position and normalised mantissa
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r2_val <= 1'b0;
      r2_p   <= '0;
      r2_m   <= '0;
      r2_idx <= '0;
      r2_grp <= '0;
    end else begin
      r2_val <= r1_val;
      if (r1_val) begin
        r2_p   <= w_p;
        r2_m   <= w_m;
        r2_idx <= r1_idx;
        r2_grp <= r1_grp;
      end
    end
  end

  // Stage 3: fraction lookup; data and tags hold while no sample emerges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      do_en         <= 1'b0;
      data_o        <= '0;
      out_group_idx <= '0;
      out_group_num <= '0;
      frame_done    <= 1'b0;
    end else begin
      do_en      <= r2_val;
      frame_done <= r2_val && (r2_idx == IDX_BW'(MEL_BINS - 1));
      if (r2_val) begin
        data_o        <= O_BW'({r2_p, LOG2_FRAC_LUT[r2_m]});
        out_group_idx <= r2_idx;
        out_group_num <= r2_grp;
      end
    end
  end

  // A frame number may only change at the start of a frame
  assign w_seq_bad = (in_group_idx != r_exp_idx) ||
                     ((in_group_num != r_last_grp) && (r_exp_idx != '0));

  // Ordering checker; next expected index always follows the accepted one,
  // which also resynchronises after an error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exp_idx  <= '0;
      r_last_grp <= '0;
      seq_err    <= 1'b0;
    end else if (di_en) begin
      r_exp_idx  <= in_group_idx + 1'b1;
      r_last_grp <= in_group_num;
      if (w_seq_bad) seq_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mel_log2.sv
// Directed bench for mel_log2 with a behavioural reference model.
module tb_mel_log2;

  logic              clk;
  logic              rst;
  logic              di_en;
  logic signed [13:0] data_i;
  logic [5:0]        in_group_idx;
  logic [6:0]        in_group_num;
  logic              do_en;
  logic [9:0]        data_o;
  logic [5:0]        out_group_idx;
  logic [6:0]        out_group_num;
  logic              frame_done;
  logic              seq_err;

  int checks = 0;
  int errors = 0;
  int n_do   = 0;
  int n_fd   = 0;

  mel_log2 #(
    .I_BW (14),
    .O_BW (10)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .di_en         (di_en),
    .data_i        (data_i),
    .in_group_idx  (in_group_idx),
    .in_group_num  (in_group_num),
    .do_en         (do_en),
    .data_o        (data_o),
    .out_group_idx (out_group_idx),
    .out_group_num (out_group_num),
    .frame_done    (frame_done),
    .seq_err       (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference log2: integer part from the leading one, fraction from real log
  function automatic int model_log2(int x);
    int  p;
    int  m;
    int  fr;
    real f;
    if (x <= 0) return 0;
    p = 0;
    while ((1 << (p + 1)) <= x) p++;
    m  = ((x - (1 << p)) * 64) / (1 << p);
    f  = 64.0 * $ln(1.0 + m / 64.0) / $ln(2.0);
    fr = $rtoi(f + 0.5);
    if (fr > 63) fr = 63;
    return p * 64 + fr;
  endfunction

  // Model state: a 3-cycle delay of (valid, result, tags) plus ordering rules
  int h_v [2];
  int h_d [2];
  int h_i [2];
  int h_g [2];
  int m_valid, m_data, m_idx, m_grp, m_err, m_exp, m_last_grp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        h_v[k] <= 0; h_d[k] <= 0; h_i[k] <= 0; h_g[k] <= 0;
      end
      m_valid <= 0; m_data <= 0; m_idx <= 0; m_grp <= 0;
      m_err <= 0; m_exp <= 0; m_last_grp <= 0;
    end else begin
      if (di_en) begin
        if ((int'(in_group_idx) != m_exp) ||
            ((int'(in_group_num) != m_last_grp) && (m_exp != 0))) m_err <= 1;
        m_exp      <= (int'(in_group_idx) + 1) % 64;
        m_last_grp <= int'(in_group_num);
      end
      h_v[0] <= int'(di_en);
      h_d[0] <= model_log2(int'(data_i));
      h_i[0] <= int'(in_group_idx);
      h_g[0] <= int'(in_group_num);
      h_v[1] <= h_v[0]; h_d[1] <= h_d[0]; h_i[1] <= h_i[0]; h_g[1] <= h_g[0];
      m_valid <= h_v[1];
      if (h_v[1] != 0) begin
        m_data <= h_d[1];
        m_idx  <= h_i[1];
        m_grp  <= h_g[1];
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare every output to the model
  task automatic tick();
    @(negedge clk);
    chk("do_en", int'(do_en), m_valid);
    chk("data_o", int'(data_o), m_data);
    chk("out_group_idx", int'(out_group_idx), m_idx);
    chk("out_group_num", int'(out_group_num), m_grp);
    chk("frame_done", int'(frame_done), int'(m_valid != 0 && m_idx == 63));
    chk("seq_err", int'(seq_err), m_err);
    n_do += int'(do_en);
    n_fd += int'(frame_done);
  endtask

  task automatic send(input int v, input int idx, input int grp);
    di_en        = 1'b1;
    data_i       = 14'(v);
    in_group_idx = 6'(idx);
    in_group_num = 7'(grp);
    tick();
  endtask

  task automatic idle(input int n);
    di_en = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    di_en = 1'b0;
    rst   = 1'b1;
    tick();
    rst   = 1'b0;
  endtask

  // One isolated sample: do_en must appear exactly on the third edge
  task automatic single(input int v, input int idx, input int lit);
    send(v, idx, 0);
    di_en = 1'b0;
    chk("lat_edge1", int'(do_en), 0);
    tick();
    chk("lat_edge2", int'(do_en), 0);
    tick();
    chk("lat_edge3", int'(do_en), 1);
    chk("lit_data", int'(data_o), lit);
    idle(2);
  endtask

  initial begin
    int d0;
    int f0;
    rst = 1'b0; di_en = 1'b0; data_i = '0; in_group_idx = '0; in_group_num = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_do_en", int'(do_en), 0);
    chk("rst_data_o", int'(data_o), 0);
    chk("rst_idx", int'(out_group_idx), 0);
    chk("rst_grp", int'(out_group_num), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_seq_err", int'(seq_err), 0);
    tick();
    tick();
    rst = 1'b0;

    // Hand-computed results pin the model as well as the DUT
    chk("model_1", model_log2(1), 0);
    chk("model_3", model_log2(3), 101);
    chk("model_8191", model_log2(8191), 831);
    single(1, 0, 0);
    single(2, 1, 64);
    single(3, 2, 101);
    single(8191, 3, 831);

    // Clamping of zero and negative input
    single(0, 4, 0);
    single(-5, 5, 0);
    chk("clamp_seq_err", int'(seq_err), 0);

    // Full back-to-back frame
    do_reset();
    d0 = n_do; f0 = n_fd;
    for (int i = 0; i < 64; i++) send((i * 523 + 7) % 8192, i, 5);
    idle(4);
    chk("frame_do_count", n_do - d0, 64);
    chk("frame_done_count", n_fd - f0, 1);
    chk("frame_grp", int'(out_group_num), 5);
    chk("frame_seq_err", int'(seq_err), 0);

    // Ordering violation 0,1,3 then 4
    do_reset();
    send(10, 0, 0);
    send(20, 1, 0);
    chk("order_pre", int'(seq_err), 0);
    send(30, 3, 0);
    chk("order_err", int'(seq_err), 1);
    send(40, 4, 0);
    idle(3);
    chk("order_sticky", int'(seq_err), 1);

    // Gapped input over two frames
    do_reset();
    d0 = n_do; f0 = n_fd;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 64; i++) begin
        send(((i + 1) * (f + 3) * 37) % 9000 - 300, i, f);
        idle(2);
      end
    end
    idle(4);
    chk("gap_do_count", n_do - d0, 128);
    chk("gap_frame_done", n_fd - f0, 2);
    chk("gap_seq_err", int'(seq_err), 0);

    // Reset while samples are in flight
    send(100, 0, 0);
    send(200, 1, 0);
    send(300, 2, 0);
    di_en = 1'b0;
    chk("pre_rst_do_en", int'(do_en), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_do_en", int'(do_en), 0);
    chk("async_data_o", int'(data_o), 0);
    chk("async_idx", int'(out_group_idx), 0);
    tick();
    rst = 1'b0;
    d0 = n_do;
    idle(5);
    chk("flush_no_out", n_do - d0, 0);
    send(50, 0, 0);
    idle(3);
    chk("post_rst_out", n_do - d0, 1);
    chk("post_rst_seq_err", int'(seq_err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mel_log2.md
MEL_LOG2 -- requirements
Module: mel_log2

Interface
REQ-001 Parameter: I_BW, 14, input sample width (signed mel energy).
REQ-002 Parameter: O_BW, 10, output width (unsigned log2, 4 integer bits, 6 fraction bits, Q4.6).
REQ-003 Port: clk  input  1  sole clock, rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: di_en  input  1  input sample valid, one sample per asserted cycle.
REQ-006 Port: data_i  input  I_BW  signed mel energy from the flow-control stage.
REQ-007 Port: in_group_idx  input  6  mel bin index within a frame, 0..63.
REQ-008 Port: in_group_num  input  7  frame number.
REQ-009 Port: do_en  output  1  output valid.
REQ-010 Port: data_o  output  O_BW  log2 result, Q4.6.
REQ-011 Port: out_group_idx  output  6  bin index aligned with data_o.
REQ-012 Port: out_group_num  output  7  frame number aligned with data_o.
REQ-013 Port: frame_done  output  1  one-cycle pulse with the output whose index is 63.
REQ-014 Port: seq_err  output  1  sticky flag for input ordering violations.

Function
REQ-015 Fixed latency of 3 cycles: a sample accepted on cycle N with di_en=1 gives do_en=1 on cycle N+3; each di_en=0 cycle gives do_en=0 three cycles later.
REQ-016 Full throughput: di_en may be high on every cycle, and arbitrary gaps are allowed; no backpressure exists.
REQ-017 Stage 1 registers the sample and its indices; data_i<=0 clamps to 0.
REQ-018 Stage 2 runs leading-one detection on the clamped value: position p (0..12) becomes the integer part, and the bits below the leading one are left-aligned into a 6-bit mantissa m, zero-padded when p<6 and truncated when p>6.
REQ-019 Stage 3 looks up frac = LUT[m], 64 entries, LUT[m] = round(log2(1+m/64)*64), max 63; data_o = {p[3:0], frac}.
REQ-020 A clamped value of 0 gives data_o=0.
REQ-021 out_group_idx and out_group_num travel with the data through all 3 stages, unmodified.
REQ-022 When do_en=0, data_o, out_group_idx and out_group_num hold their last values.
REQ-023 An expected-index counter starts at 0 after reset, advances by 1 on each accepted sample, and wraps from 63 to 0.
REQ-024 seq_err is set when a sample is accepted with in_group_idx not equal to the expected index, or when in_group_num changes while the expected index is not 0.
REQ-025 After a seq_err event, the expected index resynchronises to in_group_idx+1 (mod 64).
REQ-026 seq_err is cleared only by reset.
REQ-027 frame_done=1 exactly when do_en=1 and out_group_idx=63, otherwise 0.

Reset
REQ-028 While rst=1, immediately and regardless of clk, the following are 0: do_en, data_o, out_group_idx, out_group_num, frame_done, seq_err, all pipeline valid bits and the expected-index counter.
REQ-029 Reset asserted mid-frame discards all in-flight samples, with no output produced for them after release.
REQ-030 The first cycle after rst deasserts accepts input normally.

Structure
REQ-031 A shared package holds MEL_BINS=64, the I_BW/O_BW defaults, the index and group widths, and the 64-entry log2 fraction LUT constant.
REQ-032 Leading-one detection and normalisation form one sub-module, mel_lod_norm: combinational, input I_BW-1 bits, outputs p and m.
REQ-033 The top level contains only pipeline registers, the LUT lookup and the sequence checker.

Verification
REQ-034 Single samples: data_i = 1, 2, 3, 8191 -> data_o = 0, 64, 101, 831 (12*64+63), each with do_en exactly 3 cycles after di_en.
REQ-035 Clamping: data_i = 0 and -5 -> data_o=0, do_en=1; seq_err stays 0 when the indices are in order.
REQ-036 Full frame: 64 back-to-back samples, idx 0..63, group 5 -> 64 consecutive do_en cycles, frame_done only on the last one, out_group_num=5 throughout, seq_err=0.
REQ-037 Ordering error: idx sequence 0,1,3 -> seq_err rises 1 cycle after the idx=3 sample and stays high; a following idx 4 raises no new error.
REQ-038 Gapped input: samples every third cycle over two frames (group 0, then group 1) -> outputs match the gap pattern shifted by 3 cycles, two frame_done pulses, seq_err=0.
REQ-039 Mid-frame reset: rst pulsed while 3 samples are in flight -> no do_en afterwards until new input arrives; a new idx 0 sample after release -> seq_err=0.
